// File: rtl/al_bky_word_fetch.sv
// Fetches NWORDS 16-bit Buckeye shift words from BPI flash and strobes each into the loader FIFO.
// Optional build macro AL_FETCH_CHKSUM_EN appends a checksum word read and compare after the data words.
module al_bky_word_fetch #(
    parameter int          NWORDS    = 18,
    parameter logic [22:0] BASE_ADDR = 23'h000000,
    parameter int          TO_CYC    = 255
) (
    input  logic        CLK40,
    input  logic        RST_N,
    input  logic        START,
    input  logic        ABORT,
    input  logic        CLR_AL_DONE,
    input  logic        FIFO_AFULL,
    output logic        BPI_RD_REQ,
    output logic [22:0] BPI_ADDR,
    input  logic        BPI_RD_ACK,
    input  logic [15:0] BPI_RD_DATA,
    output logic [15:0] BPI_AL_REG,
    output logic        CAPTURE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_ACK, CAPT, NEXT, DONE_ST, ERR_ST
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);
    localparam logic [7:0] TO_LAST  = 8'(TO_CYC - 1);

    state_t      state_q;
    logic [5:0]  wordIdx_q;
    logic [7:0]  toCnt_q;
    logic        rdReq_q;
    logic [22:0] addr_q;
    logic [15:0] alReg_q;
    logic        capture_q;
    logic        done_q;
    logic        err_q;
    logic [22:0] addr_d;
    logic        busy;
`ifdef AL_FETCH_CHKSUM_EN
    logic        chkPhase_q;
    logic [15:0] sum_q;
`endif

    // Address arithmetic wraps naturally at 23 bits.
    assign addr_d = BASE_ADDR + 23'(wordIdx_q);
    assign busy   = (state_q != IDLE) && (state_q != DONE_ST) && (state_q != ERR_ST);

    always_ff @(posedge CLK40) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            wordIdx_q <= '0;
            toCnt_q   <= '0;
            rdReq_q   <= 1'b0;
            addr_q    <= '0;
            alReg_q   <= '0;
            capture_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef AL_FETCH_CHKSUM_EN
            chkPhase_q <= 1'b0;
            sum_q      <= '0;
`endif
        end else begin
            if (CLR_AL_DONE) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            // Abort beats everything, including an acknowledge arriving in the same cycle.
            if (busy && ABORT) begin
                state_q   <= IDLE;
                rdReq_q   <= 1'b0;
                capture_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (START) begin
                            state_q   <= REQ;
                            wordIdx_q <= '0;
                            toCnt_q   <= '0;
                            done_q    <= 1'b0;
                            err_q     <= 1'b0;
`ifdef AL_FETCH_CHKSUM_EN
                            chkPhase_q <= 1'b0;
                            sum_q      <= '0;
`endif
                        end
                    end
                    REQ: begin
                        if (!FIFO_AFULL) begin
                            rdReq_q <= 1'b1;
                            addr_q  <= addr_d;
                            state_q <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (BPI_RD_ACK) begin
                            rdReq_q <= 1'b0;
`ifdef AL_FETCH_CHKSUM_EN
                            if (chkPhase_q) begin
                                state_q <= (BPI_RD_DATA == sum_q) ? DONE_ST : ERR_ST;
                            end else begin
                                alReg_q   <= BPI_RD_DATA;
                                capture_q <= 1'b1;
                                sum_q     <= sum_q + BPI_RD_DATA;
                                state_q   <= CAPT;
                            end
`else
                            alReg_q   <= BPI_RD_DATA;
                            capture_q <= 1'b1;
                            state_q   <= CAPT;
`endif
                        end else if (toCnt_q == TO_LAST) begin
                            rdReq_q <= 1'b0;
                            state_q <= ERR_ST;
                        end else begin
                            toCnt_q <= toCnt_q + 8'd1;
                        end
                    end
                    CAPT: begin
                        capture_q <= 1'b0;
                        state_q   <= NEXT;
                    end
                    NEXT: begin
                        toCnt_q <= '0;
                        if (wordIdx_q == LAST_IDX) begin
`ifdef AL_FETCH_CHKSUM_EN
                            chkPhase_q <= 1'b1;
                            wordIdx_q  <= wordIdx_q + 6'd1;
                            state_q    <= REQ;
`else
                            state_q <= DONE_ST;
`endif
                        end else begin
                            wordIdx_q <= wordIdx_q + 6'd1;
                            state_q   <= REQ;
                        end
                    end
                    DONE_ST: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    ERR_ST: begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign BPI_RD_REQ = rdReq_q;
    assign BPI_ADDR   = addr_q;
    assign BPI_AL_REG = alReg_q;
    assign CAPTURE    = capture_q;
    assign BUSY       = busy;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_al_bky_word_fetch.sv
// Scoreboard bench for al_bky_word_fetch: a BPI responder model acknowledges reads,
// stimulus pushes expected words, and a monitor pops and compares on every CAPTURE.
module tb_al_bky_word_fetch;

   localparam int          NW   = 18;
   localparam logic [22:0] BASE = 23'h7FFFF8;
   localparam int          TO   = 255;

   logic        CLK40;
   logic        RST_N;
   logic        START;
   logic        ABORT;
   logic        CLR_AL_DONE;
   logic        FIFO_AFULL;
   logic        BPI_RD_REQ;
   logic [22:0] BPI_ADDR;
   logic        BPI_RD_ACK;
   logic [15:0] BPI_RD_DATA;
   logic [15:0] BPI_AL_REG;
   logic        CAPTURE;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   al_bky_word_fetch #(.NWORDS(NW), .BASE_ADDR(BASE), .TO_CYC(TO)) dut (
      .CLK40(CLK40), .RST_N(RST_N), .START(START), .ABORT(ABORT),
      .CLR_AL_DONE(CLR_AL_DONE), .FIFO_AFULL(FIFO_AFULL),
      .BPI_RD_REQ(BPI_RD_REQ), .BPI_ADDR(BPI_ADDR), .BPI_RD_ACK(BPI_RD_ACK),
      .BPI_RD_DATA(BPI_RD_DATA), .BPI_AL_REG(BPI_AL_REG), .CAPTURE(CAPTURE),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   initial CLK40 = 1'b0;
   always #5 CLK40 = ~CLK40;

   int          total = 0;
   int          bad = 0;
   logic [15:0] expQ[$];
   logic [15:0] expWord;
   int          capCount = 0;
   int          capBase = 0;

   int          ackDelay = 3;
   int          noAckIdx = -1;
   int          afullIdx = -1;
   int          abortIdx = -1;
   int          afullLeft = 0;
   int          reqRun = 0;
   int          lastReqLen = 0;
   int          afullViol = 0;
   bit          abortSeen = 0;

   // Flash content model: each word is its low address bits scrambled by a fixed pattern.
   function automatic logic [15:0] dataFor(input logic [22:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   // The base sits just below the top of the address space so every load wraps to zero.
   function automatic logic [22:0] addrOf(input int i);
      return BASE + 23'(i);
   endfunction

   // Compare one observed value against its expected value and tally the result.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulse START and/or CLR_AL_DONE for exactly one clock.
   task automatic applyStimulus(input bit doStart, input bit doClr);
      @(negedge CLK40);
      START = doStart;
      CLR_AL_DONE = doClr;
      @(negedge CLK40);
      START = 1'b0;
      CLR_AL_DONE = 1'b0;
   endtask

   // Queue the words a successful load of n words should deliver, in address order.
   task automatic pushWords(input int n);
      for (int i = 0; i < n; i++) expQ.push_back(dataFor(addrOf(i)));
   endtask

   // Wait for the fetcher to leave its busy states, failing if it never does.
   task automatic waitIdle(input string name, input int budget);
      int k;
      k = 0;
      while (BUSY && k < budget) begin
         @(negedge CLK40);
         k++;
      end
      if (BUSY) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: still busy after %0d cycles, expected idle", name, budget);
      end
   endtask

   // Monitor: every CAPTURE strobe pops one expected word from the scoreboard.
   initial begin
      forever begin
         @(negedge CLK40);
         if (CAPTURE === 1'b1) begin
            capCount++;
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected capture: got %0h expected no strobe", BPI_AL_REG);
            end else begin
               expWord = expQ.pop_front();
               checkOutput("capture data", 32'(BPI_AL_REG), 32'(expWord));
            end
         end
      end
   end

   // BPI responder: acks after ackDelay request cycles and injects abort, almost-full and no-ack events.
   initial begin
      BPI_RD_ACK = 1'b0;
      BPI_RD_DATA = '0;
      FIFO_AFULL = 1'b0;
      ABORT = 1'b0;
      forever begin
         @(negedge CLK40);
         if (ABORT) begin
            ABORT = 1'b0;
            checkOutput("busy after abort", 32'(BUSY), 32'd0);
            checkOutput("req after abort", 32'(BPI_RD_REQ), 32'd0);
            abortSeen = 1'b1;
         end
         if (FIFO_AFULL && BPI_RD_REQ) afullViol++;
         if (afullLeft > 0) begin
            afullLeft--;
            if (afullLeft == 0) FIFO_AFULL = 1'b0;
         end
         BPI_RD_ACK = 1'b0;
         if (BPI_RD_REQ) begin
            reqRun++;
            if (!(noAckIdx >= 0 && BPI_ADDR == addrOf(noAckIdx)) && reqRun == ackDelay) begin
               BPI_RD_ACK = 1'b1;
               BPI_RD_DATA = dataFor(BPI_ADDR);
               if (abortIdx >= 0 && BPI_ADDR == addrOf(abortIdx)) begin
                  ABORT = 1'b1;
                  abortIdx = -1;
               end
               if (afullIdx >= 0 && BPI_ADDR == addrOf(afullIdx)) begin
                  FIFO_AFULL = 1'b1;
                  afullLeft = 50;
                  afullIdx = -1;
               end
            end
         end else begin
            if (reqRun > 0) lastReqLen = reqRun;
            reqRun = 0;
         end
      end
   end

   // Main sequence: reset, plain load, almost-full stall, timeout, abort, mid-load reset.
   initial begin
      int k;
      RST_N = 1'b0;
      START = 1'b0;
      CLR_AL_DONE = 1'b0;
      repeat (3) @(negedge CLK40);
      checkOutput("reset req", 32'(BPI_RD_REQ), 32'd0);
      checkOutput("reset addr", 32'(BPI_ADDR), 32'd0);
      checkOutput("reset alreg", 32'(BPI_AL_REG), 32'd0);
      checkOutput("reset capture", 32'(CAPTURE), 32'd0);
      checkOutput("reset busy", 32'(BUSY), 32'd0);
      checkOutput("reset done", 32'(DONE), 32'd0);
      checkOutput("reset err", 32'(ERR), 32'd0);
      RST_N = 1'b1;

      pushWords(NW);
      capBase = capCount;
      applyStimulus(1'b1, 1'b0);
      checkOutput("busy after start", 32'(BUSY), 32'd1);
      repeat (8) @(negedge CLK40);
      applyStimulus(1'b1, 1'b0);
      waitIdle("normal load", 2000);
      repeat (2) @(negedge CLK40);
      checkOutput("normal captures", 32'(capCount - capBase), 32'd18);
      checkOutput("normal queue left", 32'(expQ.size()), 32'd0);
      checkOutput("normal done", 32'(DONE), 32'd1);
      checkOutput("normal err", 32'(ERR), 32'd0);
      checkOutput("req held until ack", 32'(lastReqLen), 32'd3);

      applyStimulus(1'b0, 1'b1);
      checkOutput("clr done", 32'(DONE), 32'd0);

      afullIdx = 4;
      pushWords(NW);
      capBase = capCount;
      applyStimulus(1'b1, 1'b0);
      waitIdle("afull load", 2000);
      repeat (2) @(negedge CLK40);
      checkOutput("afull req cycles", 32'(afullViol), 32'd0);
      checkOutput("afull captures", 32'(capCount - capBase), 32'd18);
      checkOutput("afull queue left", 32'(expQ.size()), 32'd0);
      checkOutput("afull done", 32'(DONE), 32'd1);

      noAckIdx = 2;
      pushWords(2);
      capBase = capCount;
      applyStimulus(1'b1, 1'b0);
      checkOutput("done cleared by start", 32'(DONE), 32'd0);
      waitIdle("timeout load", 2000);
      repeat (2) @(negedge CLK40);
      noAckIdx = -1;
      checkOutput("timeout err", 32'(ERR), 32'd1);
      checkOutput("timeout done", 32'(DONE), 32'd0);
      checkOutput("timeout captures", 32'(capCount - capBase), 32'd2);
      checkOutput("timeout req length", 32'(lastReqLen), 32'd255);

      abortIdx = 10;
      abortSeen = 1'b0;
      pushWords(NW);
      capBase = capCount;
      applyStimulus(1'b1, 1'b1);
      checkOutput("start beats clr err", 32'(ERR), 32'd0);
      checkOutput("start beats clr busy", 32'(BUSY), 32'd1);
      k = 0;
      while (!abortSeen && k < 2000) begin
         @(negedge CLK40);
         k++;
      end
      checkOutput("abort reached", 32'(abortSeen), 32'd1);
      repeat (3) @(negedge CLK40);
      checkOutput("abort captures", 32'(capCount - capBase), 32'd10);
      checkOutput("abort queue left", 32'(expQ.size()), 32'd8);
      checkOutput("abort busy", 32'(BUSY), 32'd0);
      checkOutput("abort done", 32'(DONE), 32'd0);
      checkOutput("abort err", 32'(ERR), 32'd0);
      expQ.delete();

      pushWords(NW);
      capBase = capCount;
      applyStimulus(1'b1, 1'b0);
      k = 0;
      while (!(BPI_RD_REQ && BPI_ADDR == addrOf(7)) && k < 2000) begin
         @(negedge CLK40);
         k++;
      end
      checkOutput("word 7 requested", 32'(BPI_ADDR), 32'(addrOf(7)));
      RST_N = 1'b0;
      repeat (2) @(negedge CLK40);
      checkOutput("midreset busy", 32'(BUSY), 32'd0);
      checkOutput("midreset req", 32'(BPI_RD_REQ), 32'd0);
      checkOutput("midreset addr", 32'(BPI_ADDR), 32'd0);
      checkOutput("midreset alreg", 32'(BPI_AL_REG), 32'd0);
      checkOutput("midreset captures", 32'(capCount - capBase), 32'd7);
      RST_N = 1'b1;
      expQ.delete();
      repeat (3) @(negedge CLK40);
      checkOutput("no capture after reset", 32'(capCount - capBase), 32'd7);

      pushWords(NW);
      capBase = capCount;
      applyStimulus(1'b1, 1'b0);
      waitIdle("restart load", 2000);
      repeat (2) @(negedge CLK40);
      checkOutput("restart captures", 32'(capCount - capBase), 32'd18);
      checkOutput("restart queue left", 32'(expQ.size()), 32'd0);
      checkOutput("restart done", 32'(DONE), 32'd1);
      checkOutput("restart err", 32'(ERR), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Backstop in case a wait above ever stops advancing.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
